// File: rtl/bram_seq_pkg.sv
// bram_seq_pkg: command, bank and state encodings shared by the BRAM sequencer
package bram_seq_pkg;
  typedef enum logic [1:0] {CMD_WRITE, CMD_READ, CMD_FILL, CMD_CHECKSUM} cmd_t;
  typedef enum logic [1:0] {BANK_ADDR, BANK_DATA, BANK_LEN, BANK_CMD} bank_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CLK_HI, S_CLK_LO, S_NEXT, S_DONE} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser with a single-cycle rising-edge pulse
module sync_edge_detect (
  input  logic sysclk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sh;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else sh <= {sh[1:0], d};
  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/bram_seq_engine.sv
// bram_seq_engine: host-loaded sequencer driving one block-RAM port with a fabric-generated mem clock
module bram_seq_engine
  import bram_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 13,
  parameter int CLK_DIV  = 1,
  parameter int READ_LAT = 2
) (
  input  logic              sysclk,
  input  logic              external_reset_n,
  input  logic [DATA_W-1:0] external_data_in,
  input  logic [1:0]        external_data_bank,
  input  logic              external_data_clock,
  input  logic              external_execute,
  output logic [DATA_W-1:0] external_data_out,
  output logic              external_isfinished,
  output logic              mem_clk,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic              mem_reset,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int LW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  state_t state;
  cmd_t cmd;
  logic load, exec, div_end, lat_end, single, wr;
  logic [ADDR_W-1:0] addr, waddr;
  logic [ADDR_W:0] len, cnt, cnt_nx;
  logic [DATA_W-1:0] data, sum;
  logic [DW-1:0] div;
  logic [LW-1:0] lat;
  sync_edge_detect u_load (.sysclk(sysclk), .rst_n(external_reset_n), .d(external_data_clock), .rise(load));
  sync_edge_detect u_exec (.sysclk(sysclk), .rst_n(external_reset_n), .d(external_execute), .rise(exec));
  assign div_end = div == DW'(CLK_DIV - 1);
  assign lat_end = lat == LW'(READ_LAT - 1);
  assign single = ~cmd[1];
  assign wr = ~cmd[0];
  assign cnt_nx = cnt + 1'b1;
  assign mem_reset = 1'b0;
  // every mem_* change happens while mem_clk is low, giving CLK_DIV cycles of setup and hold
  always_ff @(posedge sysclk or negedge external_reset_n)
    if (!external_reset_n) begin
      state <= S_IDLE;
      cmd <= CMD_WRITE;
      addr <= '0;
      waddr <= '0;
      len <= '0;
      cnt <= '0;
      data <= '0;
      sum <= '0;
      div <= '0;
      lat <= '0;
      external_data_out <= '0;
      external_isfinished <= 1'b1;
      mem_clk <= 1'b0;
      mem_ce <= 1'b0;
      mem_oce <= 1'b0;
      mem_wre <= 1'b0;
      mem_ad <= '0;
      mem_din <= '0;
    end else case (state)
      S_IDLE: begin
        if (load) case (bank_t'(external_data_bank))
          BANK_ADDR: addr <= ADDR_W'({addr, external_data_in});
          BANK_DATA: data <= external_data_in;
          BANK_LEN:  len <= (ADDR_W+1)'({len, external_data_in});
          default:   cmd <= cmd_t'(external_data_in[1:0]);
        endcase
        if (exec) begin
          external_isfinished <= 1'b0;
          waddr <= addr;
          cnt <= '0;
          sum <= '0;
          div <= '0;
          lat <= '0;
          if (!single && len == '0) state <= S_DONE;
          else begin
            state <= S_SETUP;
            mem_ce <= 1'b1;
            mem_oce <= 1'b1;
            mem_ad <= addr;
            mem_din <= data;
            mem_wre <= wr;
          end
        end
      end
      S_SETUP: if (div_end) begin
        div <= '0;
        mem_clk <= 1'b1;
        state <= S_CLK_HI;
      end else div <= div + 1'b1;
      S_CLK_HI: if (div_end) begin
        div <= '0;
        mem_clk <= 1'b0;
        state <= S_CLK_LO;
      end else div <= div + 1'b1;
      S_CLK_LO: if (!div_end) div <= div + 1'b1;
      else begin
        div <= '0;
        // reads run READ_LAT full mem_clk periods, then sample on the last low cycle
        if (!wr && !lat_end) begin
          lat <= lat + 1'b1;
          mem_clk <= 1'b1;
          state <= S_CLK_HI;
        end else begin
          if (!wr) sum <= sum + mem_dout;
          state <= S_NEXT;
        end
      end
      S_NEXT: begin
        cnt <= cnt_nx;
        waddr <= waddr + 1'b1;
        lat <= '0;
        if (single || cnt_nx >= len) begin
          state <= S_DONE;
          mem_ce <= 1'b0;
          mem_oce <= 1'b0;
          mem_wre <= 1'b0;
        end else begin
          state <= S_SETUP;
          mem_ad <= waddr + 1'b1;
        end
      end
      S_DONE: begin
        external_isfinished <= 1'b1;
        if (!wr) external_data_out <= sum;
        state <= S_IDLE;
      end
      default: state <= S_IDLE;
    endcase
endmodule

// File: tb/tb_bram_seq_engine.sv
// tb_bram_seq_engine: directed checks of two engines (default and CLK_DIV=3/READ_LAT=1) on RAM models
module tb_bram_seq_engine;
  logic sysclk = 1'b0, rst_n = 1'b0, dclk = 1'b0, exe = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] bank = 2'd0;
  logic [7:0] out0, out1, mdin0, mdin1, dout0, dout1, q0;
  logic fin0, fin1, mclk0, mclk1, ce0, ce1, oce0, oce1, wre0, wre1, mrst0, mrst1;
  logic [12:0] ad0, ad1;
  logic [7:0] ram0 [8192];
  logic [7:0] ram1 [8192];
  logic wre_seen;
  int n_checks = 0, n_fail = 0;

  always #5 sysclk = ~sysclk;

  bram_seq_engine #(.DATA_W(8), .ADDR_W(13), .CLK_DIV(1), .READ_LAT(2)) dut0 (
    .sysclk(sysclk), .external_reset_n(rst_n), .external_data_in(din), .external_data_bank(bank),
    .external_data_clock(dclk), .external_execute(exe), .external_data_out(out0),
    .external_isfinished(fin0), .mem_clk(mclk0), .mem_ce(ce0), .mem_oce(oce0), .mem_wre(wre0),
    .mem_reset(mrst0), .mem_ad(ad0), .mem_din(mdin0), .mem_dout(dout0));

  bram_seq_engine #(.DATA_W(8), .ADDR_W(13), .CLK_DIV(3), .READ_LAT(1)) dut1 (
    .sysclk(sysclk), .external_reset_n(rst_n), .external_data_in(din), .external_data_bank(bank),
    .external_data_clock(dclk), .external_execute(exe), .external_data_out(out1),
    .external_isfinished(fin1), .mem_clk(mclk1), .mem_ce(ce1), .mem_oce(oce1), .mem_wre(wre1),
    .mem_reset(mrst1), .mem_ad(ad1), .mem_din(mdin1), .mem_dout(dout1));

  // Gowin_DPB-like port A: registered read, optional OCE output register
  always @(posedge mclk0) begin
    if (oce0) dout0 = q0;
    if (ce0) begin
      if (wre0) ram0[ad0] = mdin0;
      else q0 = ram0[ad0];
    end
  end

  always @(posedge mclk1)
    if (ce1) begin
      if (wre1) ram1[ad1] = mdin1;
      else dout1 = ram1[ad1];
    end

  always @(posedge sysclk) if (wre0 || wre1) wre_seen = 1'b1;

  function automatic logic [7:0] out_of(input int i);
    return i != 0 ? out1 : out0;
  endfunction

  function automatic logic fin_of(input int i);
    return i != 0 ? fin1 : fin0;
  endfunction

  function automatic logic [7:0] ram_of(input int i, input logic [12:0] a);
    return i != 0 ? ram1[a] : ram0[a];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic strobe(input logic [1:0] b, input logic [7:0] v);
    bank = b;
    din = v;
    dclk = 1'b1;
    cyc(4);
    dclk = 1'b0;
    cyc(4);
  endtask

  task automatic load16(input logic [1:0] b, input logic [15:0] v);
    strobe(b, v[15:8]);
    strobe(b, v[7:0]);
  endtask

  task automatic pulse_exec;
    exe = 1'b1;
    cyc(4);
    exe = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(fin0 && fin1) && n < 5000) begin
      cyc(1);
      n++;
    end
    n_checks++;
    if (!(fin0 && fin1)) begin
      n_fail++;
      $display("FAIL %s timeout: isfinished %b%b, expected 11", tag, fin0, fin1);
    end
  endtask

  task automatic run(input logic [1:0] c, input string tag);
    strobe(2'd3, {6'd0, c});
    pulse_exec();
    wait_done(tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      n_checks += 3;
      if (fin_of(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_fin inst%0d: got %b expected 1", i, fin_of(i));
      end
      if (out_of(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_out inst%0d: got %h expected 00", i, out_of(i));
      end
      if ((i != 0 ? {mclk1, ce1, oce1, wre1, mrst1} : {mclk0, ce0, oce0, wre0, mrst0}) !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_mem inst%0d: clk/ce/oce/wre/reset not all 0", i);
      end
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_write_read;
    logic [12:0] wa [3] = '{13'h0000, 13'h0005, 13'h1ABC};
    logic [7:0] wv [3] = '{8'hAA, 8'h3C, 8'h01};
    logic [7:0] prev = 8'h00;
    for (int k = 0; k < 3; k++) begin
      load16(2'd0, {3'd0, wa[k]});
      strobe(2'd1, wv[k]);
      run(2'd0, "write");
      for (int i = 0; i < 2; i++) begin
        n_checks += 2;
        if (ram_of(i, wa[k]) !== wv[k]) begin
          n_fail++;
          $display("FAIL write inst%0d addr %h: ram %h expected %h", i, wa[k], ram_of(i, wa[k]), wv[k]);
        end
        if (out_of(i) !== prev) begin
          n_fail++;
          $display("FAIL write_keeps_out inst%0d: got %h expected %h", i, out_of(i), prev);
        end
      end
      run(2'd1, "read");
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (out_of(i) !== wv[k]) begin
          n_fail++;
          $display("FAIL read inst%0d addr %h: got %h expected %h", i, wa[k], out_of(i), wv[k]);
        end
      end
      prev = wv[k];
    end
  endtask

  task automatic test_fill_checksum;
    ram0[13'h0110] = 8'h77; ram1[13'h0110] = 8'h77;
    ram0[13'h00FF] = 8'h66; ram1[13'h00FF] = 8'h66;
    load16(2'd0, 16'h0100);
    load16(2'd2, 16'd16);
    strobe(2'd1, 8'h5A);
    run(2'd2, "fill");
    for (int i = 0; i < 2; i++) begin
      n_checks += 4;
      if (ram_of(i, 13'h0100) !== 8'h5A || ram_of(i, 13'h010F) !== 8'h5A) begin
        n_fail++;
        $display("FAIL fill_range inst%0d: first %h last %h expected 5a", i, ram_of(i, 13'h0100), ram_of(i, 13'h010F));
      end
      if (ram_of(i, 13'h0110) !== 8'h77) begin
        n_fail++;
        $display("FAIL fill_after inst%0d: got %h expected 77", i, ram_of(i, 13'h0110));
      end
      if (ram_of(i, 13'h00FF) !== 8'h66) begin
        n_fail++;
        $display("FAIL fill_before inst%0d: got %h expected 66", i, ram_of(i, 13'h00FF));
      end
      if (out_of(i) !== 8'h01) begin
        n_fail++;
        $display("FAIL fill_keeps_out inst%0d: got %h expected 01", i, out_of(i));
      end
    end
    run(2'd3, "checksum");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_of(i) !== 8'hA0) begin
        n_fail++;
        $display("FAIL checksum inst%0d: got %h expected a0", i, out_of(i));
      end
    end
  endtask

  task automatic test_wrap;
    ram0[13'h1FFE] = 8'h11; ram1[13'h1FFE] = 8'h11;
    load16(2'd0, 16'h1FFF);
    load16(2'd2, 16'd2);
    strobe(2'd1, 8'h33);
    run(2'd2, "wrap_fill");
    run(2'd1, "wrap_read");
    for (int i = 0; i < 2; i++) begin
      n_checks += 3;
      if (ram_of(i, 13'h1FFF) !== 8'h33 || ram_of(i, 13'h0000) !== 8'h33) begin
        n_fail++;
        $display("FAIL wrap_fill inst%0d: 1fff=%h 0000=%h expected 33", i, ram_of(i, 13'h1FFF), ram_of(i, 13'h0000));
      end
      if (ram_of(i, 13'h1FFE) !== 8'h11) begin
        n_fail++;
        $display("FAIL wrap_below inst%0d: got %h expected 11", i, ram_of(i, 13'h1FFE));
      end
      if (out_of(i) !== 8'h33) begin
        n_fail++;
        $display("FAIL addr_kept inst%0d: read got %h expected 33", i, out_of(i));
      end
    end
  endtask

  task automatic test_len_zero;
    int lo0 = 0, lo1 = 0;
    load16(2'd2, 16'd0);
    strobe(2'd3, 8'd2);
    wre_seen = 1'b0;
    exe = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      if (c == 3) exe = 1'b0;
      lo0 += fin0 ? 0 : 1;
      lo1 += fin1 ? 0 : 1;
    end
    n_checks += 3;
    if (wre_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_wre: mem_wre seen %b expected 0", wre_seen);
    end
    if (lo0 < 1 || lo0 > 2 || lo1 < 1 || lo1 > 2) begin
      n_fail++;
      $display("FAIL len0_busy: busy cycles %0d/%0d expected 1..2", lo0, lo1);
    end
    if (!(fin0 && fin1)) begin
      n_fail++;
      $display("FAIL len0_done: isfinished %b%b expected 11", fin0, fin1);
    end
    run(2'd3, "len0_checksum");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_of(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL len0_checksum inst%0d: got %h expected 00", i, out_of(i));
      end
    end
  endtask

  task automatic test_busy_ignored;
    load16(2'd0, 16'h0100);
    load16(2'd2, 16'd16);
    strobe(2'd1, 8'h5A);
    strobe(2'd3, 8'd3);
    pulse_exec();
    strobe(2'd1, 8'hEE);
    strobe(2'd3, 8'd0);
    load16(2'd0, 16'h0200);
    pulse_exec();
    n_checks++;
    if (fin0 !== 1'b0 || fin1 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_window: isfinished %b%b expected 00", fin0, fin1);
    end
    wait_done("busy_checksum");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_of(i) !== 8'hA0) begin
        n_fail++;
        $display("FAIL busy_checksum inst%0d: got %h expected a0", i, out_of(i));
      end
    end
    pulse_exec();
    wait_done("rerun_checksum");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_of(i) !== 8'hA0) begin
        n_fail++;
        $display("FAIL regs_kept inst%0d: got %h expected a0", i, out_of(i));
      end
    end
    run(2'd0, "busy_write");
    for (int i = 0; i < 2; i++) begin
      n_checks += 2;
      if (ram_of(i, 13'h0100) !== 8'h5A) begin
        n_fail++;
        $display("FAIL data_kept inst%0d: ram %h expected 5a", i, ram_of(i, 13'h0100));
      end
      if (ram_of(i, 13'h0200) !== 8'h00) begin
        n_fail++;
        $display("FAIL addr_not_loaded inst%0d: ram[200] %h expected 00", i, ram_of(i, 13'h0200));
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    load16(2'd0, 16'h0400);
    load16(2'd2, 16'd64);
    strobe(2'd1, 8'h99);
    strobe(2'd3, 8'd2);
    pulse_exec();
    cyc(20);
    n_checks++;
    if (ce0 !== 1'b1 || ce1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midfill_active: mem_ce %b%b expected 11", ce0, ce1);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 3;
      if ((i != 0 ? {wre1, ce1} : {wre0, ce0}) !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_mem inst%0d: wre/ce not 00", i);
      end
      if (fin_of(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_fin inst%0d: got %b expected 1", i, fin_of(i));
      end
      if (out_of(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL abort_out inst%0d: got %h expected 00", i, out_of(i));
      end
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ram_of(i, 13'h0400) !== 8'h99 || ram_of(i, 13'h043F) !== 8'h00) begin
        n_fail++;
        $display("FAIL partial_fill inst%0d: 400=%h 43f=%h expected 99/00", i, ram_of(i, 13'h0400), ram_of(i, 13'h043F));
      end
    end
    load16(2'd0, 16'h0050);
    strobe(2'd1, 8'h42);
    run(2'd0, "post_reset_write");
    run(2'd1, "post_reset_read");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_of(i) !== 8'h42 || ram_of(i, 13'h0050) !== 8'h42) begin
        n_fail++;
        $display("FAIL post_reset inst%0d: out %h ram %h expected 42", i, out_of(i), ram_of(i, 13'h0050));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) begin
      ram0[a] = 8'h00;
      ram1[a] = 8'h00;
    end
    q0 = 8'h00;
    dout0 = 8'h00;
    dout1 = 8'h00;
    wre_seen = 1'b0;
    test_reset();
    test_write_read();
    test_fill_checksum();
    test_wrap();
    test_len_zero();
    test_busy_ignored();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
